// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths and the EX/MEM pipeline bundle.
// Latency: none; this file holds only types, constants and a helper function.
// Backpressure: not applicable.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Everything the memory and write-back stages need from one instruction.
    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic              alu_zero;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  dst_reg;
        logic [DATA_W-1:0] branch_target;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              branch_ne;
        logic              branch_taken;
    } ex_mem_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);

    // BEQ is taken on Zero, BNE on !Zero; non-branches are never taken.
    function automatic logic branch_resolve(input logic branch,
                                            input logic branch_ne,
                                            input logic zero);
        return branch & (zero ^ branch_ne);
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer (main drives the output, skid absorbs one stall).
// Latency: 1 cycle from input transfer to out_vld_o when empty; 1 item/cycle sustained.
// Backpressure: in_rdy_o is registered and drops the cycle after skid fills; flush_i empties both entries.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] out_dat_o
);

    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_rdy_q, in_rdy_d;
    logic [WIDTH-1:0] main_dat_q, main_dat_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             in_xfer;

    assign in_xfer = in_vld_i & in_rdy_q;

    // Next-state: refill main from skid first (keeps FIFO order), else from the input.
    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (flush_i) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_rdy_i) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_dat_d = skid_dat_q;
                skid_vld_d = in_xfer;
                if (in_xfer) begin
                    skid_dat_d = in_dat_i;
                end
            end else begin
                main_vld_d = in_xfer;
                skid_vld_d = 1'b0;
                if (in_xfer) begin
                    main_dat_d = in_dat_i;
                end
            end
        end else if (in_xfer) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat_i;
        end
        in_rdy_d = ~skid_vld_d;
    end

    // State registers; data is cleared on reset so outputs start at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b1;
            main_dat_q <= '0;
            skid_dat_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= in_rdy_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
        end
    end

    assign in_rdy_o  = in_rdy_q;
    assign out_vld_o = main_vld_q;
    assign out_dat_o = main_dat_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result, store data, dest reg, control and branch decision.
// Latency: 1 cycle when empty; full throughput while out_ready is high.
// Backpressure: two-entry skid buffer, registered in_ready; flush discards held and incoming bundles.
module ex_mem_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  dst_reg,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              ctrl_reg_write,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_mem_write,
    input  logic              ctrl_mem_to_reg,
    input  logic              ctrl_branch,
    input  logic              ctrl_branch_ne,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic              out_alu_zero,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_dst_reg,
    output logic [DATA_W-1:0] out_branch_target,
    output logic              out_ctrl_reg_write,
    output logic              out_ctrl_mem_read,
    output logic              out_ctrl_mem_write,
    output logic              out_ctrl_mem_to_reg,
    output logic              out_ctrl_branch,
    output logic              out_ctrl_branch_ne,
    output logic              out_branch_taken,
    output logic [DATA_W-1:0] out_branch_pc
);

    ex_mem_t in_bundle;
    ex_mem_t out_bundle;

    // Pack the EX outputs; the branch decision is frozen here and travels with the bundle.
    always_comb begin
        in_bundle               = '0;
        in_bundle.alu_result    = alu_result;
        in_bundle.alu_zero      = alu_zero;
        in_bundle.store_data    = store_data;
        in_bundle.dst_reg       = dst_reg;
        in_bundle.branch_target = branch_target;
        in_bundle.reg_write     = ctrl_reg_write;
        in_bundle.mem_read      = ctrl_mem_read;
        in_bundle.mem_write     = ctrl_mem_write;
        in_bundle.mem_to_reg    = ctrl_mem_to_reg;
        in_bundle.branch        = ctrl_branch;
        in_bundle.branch_ne     = ctrl_branch_ne;
        in_bundle.branch_taken  = branch_resolve(ctrl_branch, ctrl_branch_ne, alu_zero);
    end

    skid_buffer #(
        .WIDTH (EX_MEM_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .in_vld_i  (in_valid),
        .in_rdy_o  (in_ready),
        .in_dat_i  (in_bundle),
        .out_vld_o (out_valid),
        .out_rdy_i (out_ready),
        .out_dat_o (out_bundle)
    );

    assign out_alu_result      = out_bundle.alu_result;
    assign out_alu_zero        = out_bundle.alu_zero;
    assign out_store_data      = out_bundle.store_data;
    assign out_dst_reg         = out_bundle.dst_reg;
    assign out_branch_target   = out_bundle.branch_target;
    assign out_ctrl_reg_write  = out_bundle.reg_write;
    assign out_ctrl_mem_read   = out_bundle.mem_read;
    assign out_ctrl_mem_write  = out_bundle.mem_write;
    assign out_ctrl_mem_to_reg = out_bundle.mem_to_reg;
    assign out_ctrl_branch     = out_bundle.branch;
    assign out_ctrl_branch_ne  = out_bundle.branch_ne;
    assign out_branch_taken    = out_bundle.branch_taken;
    assign out_branch_pc       = out_bundle.branch_target;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
    import mips_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dst_reg;
    logic [DATA_W-1:0] branch_target;
    logic              ctrl_reg_write, ctrl_mem_read, ctrl_mem_write;
    logic              ctrl_mem_to_reg, ctrl_branch, ctrl_branch_ne;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_alu_result;
    logic              out_alu_zero;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_W-1:0]  out_dst_reg;
    logic [DATA_W-1:0] out_branch_target;
    logic              out_ctrl_reg_write, out_ctrl_mem_read, out_ctrl_mem_write;
    logic              out_ctrl_mem_to_reg, out_ctrl_branch, out_ctrl_branch_ne;
    logic              out_branch_taken;
    logic [DATA_W-1:0] out_branch_pc;

    ex_mem_stage dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .alu_result          (alu_result),
        .alu_zero            (alu_zero),
        .store_data          (store_data),
        .dst_reg             (dst_reg),
        .branch_target       (branch_target),
        .ctrl_reg_write      (ctrl_reg_write),
        .ctrl_mem_read       (ctrl_mem_read),
        .ctrl_mem_write      (ctrl_mem_write),
        .ctrl_mem_to_reg     (ctrl_mem_to_reg),
        .ctrl_branch         (ctrl_branch),
        .ctrl_branch_ne      (ctrl_branch_ne),
        .flush               (flush),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_alu_result      (out_alu_result),
        .out_alu_zero        (out_alu_zero),
        .out_store_data      (out_store_data),
        .out_dst_reg         (out_dst_reg),
        .out_branch_target   (out_branch_target),
        .out_ctrl_reg_write  (out_ctrl_reg_write),
        .out_ctrl_mem_read   (out_ctrl_mem_read),
        .out_ctrl_mem_write  (out_ctrl_mem_write),
        .out_ctrl_mem_to_reg (out_ctrl_mem_to_reg),
        .out_ctrl_branch     (out_ctrl_branch),
        .out_ctrl_branch_ne  (out_ctrl_branch_ne),
        .out_branch_taken    (out_branch_taken),
        .out_branch_pc       (out_branch_pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: an ordered list of held bundles (capacity two) plus the
    // value the outputs keep showing once the list runs dry.
    ex_mem_t     mq[$];
    ex_mem_t     m_last;
    logic        m_in_rdy;
    logic [31:0] log_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ex_mem_t expect_in();
        ex_mem_t b;
        b.alu_result    = alu_result;
        b.alu_zero      = alu_zero;
        b.store_data    = store_data;
        b.dst_reg       = dst_reg;
        b.branch_target = branch_target;
        b.reg_write     = ctrl_reg_write;
        b.mem_read      = ctrl_mem_read;
        b.mem_write     = ctrl_mem_write;
        b.mem_to_reg    = ctrl_mem_to_reg;
        b.branch        = ctrl_branch;
        b.branch_ne     = ctrl_branch_ne;
        if (!ctrl_branch)        b.branch_taken = 1'b0;
        else if (ctrl_branch_ne) b.branch_taken = (alu_zero == 1'b0);
        else                     b.branch_taken = (alu_zero == 1'b1);
        return b;
    endfunction

    function automatic ex_mem_t observed();
        ex_mem_t b;
        b.alu_result    = out_alu_result;
        b.alu_zero      = out_alu_zero;
        b.store_data    = out_store_data;
        b.dst_reg       = out_dst_reg;
        b.branch_target = out_branch_target;
        b.reg_write     = out_ctrl_reg_write;
        b.mem_read      = out_ctrl_mem_read;
        b.mem_write     = out_ctrl_mem_write;
        b.mem_to_reg    = out_ctrl_mem_to_reg;
        b.branch        = out_ctrl_branch;
        b.branch_ne     = out_ctrl_branch_ne;
        b.branch_taken  = out_branch_taken;
        return b;
    endfunction

    task automatic set_in(input logic [31:0] res, input logic z, input logic br,
                          input logic ne, input logic [31:0] tgt);
        alu_result      = res;
        alu_zero        = z;
        store_data      = res ^ 32'hA5A5_0000;
        dst_reg         = res[4:0];
        branch_target   = tgt;
        ctrl_reg_write  = !br;
        ctrl_mem_read   = 1'b0;
        ctrl_mem_write  = 1'b0;
        ctrl_mem_to_reg = 1'b0;
        ctrl_branch     = br;
        ctrl_branch_ne  = ne;
    endtask

    task automatic set_rand();
        alu_result      = $urandom;
        alu_zero        = 1'($urandom_range(1));
        store_data      = $urandom;
        dst_reg         = 5'($urandom);
        branch_target   = $urandom;
        ctrl_reg_write  = 1'($urandom_range(1));
        ctrl_mem_read   = 1'($urandom_range(1));
        ctrl_mem_write  = 1'($urandom_range(1));
        ctrl_mem_to_reg = 1'($urandom_range(1));
        ctrl_branch     = 1'($urandom_range(1));
        ctrl_branch_ne  = 1'($urandom_range(1));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        logic    in_x, out_x;
        ex_mem_t nb;
        in_x = in_valid && m_in_rdy;
        out_x = (mq.size() > 0) && out_ready;
        nb = expect_in();
        if (rst_n && !flush && out_valid && out_ready) log_q.push_back(out_alu_result);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            m_in_rdy = 1'b1;
            m_last = '0;
        end else if (flush) begin
            mq.delete();
            m_in_rdy = 1'b1;
        end else begin
            if (out_x) void'(mq.pop_front());
            if (in_x) mq.push_back(nb);
            m_in_rdy = (mq.size() < 2);
        end
        if (mq.size() > 0) m_last = mq[0];
        chk("in_ready", 128'(in_ready), 128'(m_in_rdy));
        chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
        chk("bundle", 128'(observed()), 128'(m_last));
        chk("branch_pc", 128'(out_branch_pc), 128'(m_last.branch_target));
    endtask

    initial begin
        m_in_rdy = 1'b1;
        m_last   = '0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_in(32'h55, 1'b1, 1'b1, 1'b0, 32'h1234);

        // Reset held for two cycles with a valid input offered.
        tick();
        tick();
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_ready", 128'(in_ready), 128'd1);
        chk("rst_zero", 128'(observed()), 128'd0);

        // Eight back-to-back ADD bundles.
        rst_n = 1'b1;
        log_q.delete();
        for (int i = 1; i <= 8; i++) begin
            set_in(32'(i), 1'b0, 1'b0, 1'b0, 32'h0);
            tick();
            if (i == 1) begin
                chk("lat1_valid", 128'(out_valid), 128'd1);
                chk("lat1_result", 128'(out_alu_result), 128'd1);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("stream_count", 128'(log_q.size()), 128'd8);
        for (int i = 0; i < log_q.size(); i++) chk("stream_order", 128'(log_q[i]), 128'(i + 1));

        // Backpressure after bundle 3.
        log_q.delete();
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_in(32'(i), 1'b0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        out_ready = 1'b0;
        set_in(32'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("bp_ready_low", 128'(in_ready), 128'd0);
        chk("bp_main_holds", 128'(out_alu_result), 128'd3);
        set_in(32'd5, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        chk("bp_ready_back", 128'(in_ready), 128'd1);
        chk("bp_skid_moved", 128'(out_alu_result), 128'd4);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("bp_count", 128'(log_q.size()), 128'd5);
        for (int i = 0; i < log_q.size(); i++) chk("bp_order", 128'(log_q[i]), 128'(i + 1));

        // Branch resolution captured with the bundle.
        in_valid = 1'b1;
        set_in(32'h0, 1'b1, 1'b1, 1'b0, 32'h0040_0010);
        tick();
        chk("beq_taken", 128'(out_branch_taken), 128'd1);
        chk("beq_pc", 128'(out_branch_pc), 128'h0040_0010);
        set_in(32'h0, 1'b1, 1'b1, 1'b1, 32'h0040_0020);
        tick();
        chk("bne_not_taken", 128'(out_branch_taken), 128'd0);
        in_valid = 1'b0;
        tick();

        // Flush with both entries full and a valid input offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(32'hA, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(32'hB, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("fl_full", 128'(in_ready), 128'd0);
        log_q.delete();
        flush = 1'b1;
        set_in(32'hC, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("fl_valid", 128'(out_valid), 128'd0);
        chk("fl_ready", 128'(in_ready), 128'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_nothing_out", 128'(log_q.size()), 128'd0);

        // Reset for one cycle in the middle of a stalled stream.
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_in(32'hD, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(32'hE, 1'b1, 1'b1, 1'b0, 32'h77);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mr_valid", 128'(out_valid), 128'd0);
        chk("mr_ready", 128'(in_ready), 128'd1);
        chk("mr_zero", 128'(observed()), 128'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_in(32'hF, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("mr_lat_valid", 128'(out_valid), 128'd1);
        chk("mr_lat_result", 128'(out_alu_result), 128'hF);
        in_valid = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            set_rand();
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(39) == 0);
            rst_n     = ($urandom_range(149) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
